dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_array.sv | 46 ++++
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
//               - state_e : responder FSM states (IDLE / WAIT / RESP)
//               - DATA_W  : data word width in bits
//               - BE_W    : byte-enable width (one bit per data byte)
//               - CNT_W   : wait-state counter width (holds 0..15)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word-organised storage with one synchronous byte-enabled
//               write port and one combinational read port. Contents are
//               deliberately not reset.
// Ports       : clk     - clock, writes on rising edge
//               wr_en   - write strobe
//               wr_idx  - word index to write
//               wr_data - write data
//               wr_be   - per-byte write enables
//               rd_idx  - word index to read
//               rd_data - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder. Accepts one
//               load/store request, waits WAIT_STATES cycles, then presents
//               a response held until the initiator takes it.
// Ports       : clk        - clock
//               rst        - asynchronous reset, active low
//               req_valid  - request present          (in)
//               req_ready  - request can be accepted  (out)
//               req_we     - 1 = store, 0 = load      (in)
//               req_addr   - byte address             (in, 32b)
//               req_wdata  - store data               (in, 32b)
//               req_be     - store byte enables       (in, 4b)
//               rsp_valid  - response present         (out)
//               rsp_ready  - response accepted        (in)
//               rsp_rdata  - load data, 0 on store/error (out, 32b)
//               rsp_err    - misaligned / out-of-range (out)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  // Counter preload; unused when there are no wait states.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               bad_q, bad_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               accept;
  logic               req_bad;
  logic               enter_resp;
  logic               txn_we;
  logic [ADDR_W-1:0]  txn_idx;
  logic [DATA_W-1:0]  txn_wdata;
  logic [BE_W-1:0]    txn_be;
  logic               txn_bad;
  logic               mem_wr_en;
  logic [DATA_W-1:0]  mem_rd_data;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_bad = (req_addr[1:0] != 2'b00) ||
                   (req_addr[31:2] >= 30'(DEPTH_WORDS));

  // With zero wait states RESP is entered on the accepting edge itself, so
  // the commit must use the live request; otherwise the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      txn_we    = req_we;
      txn_idx   = req_addr[ADDR_W+1:2];
      txn_wdata = req_wdata;
      txn_be    = req_be;
      txn_bad   = req_bad;
    end else begin
      txn_we    = we_q;
      txn_idx   = idx_q;
      txn_wdata = wdata_q;
      txn_be    = be_q;
      txn_bad   = bad_q;
    end
  end

  assign enter_resp = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == '0));
  assign mem_wr_en  = enter_resp && txn_we && !txn_bad;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_idx  (txn_idx),
    .wr_data (txn_wdata),
    .wr_be   (txn_be),
    .rd_idx  (txn_idx),
    .rd_data (mem_rd_data)
  );

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture and response data.
  always_comb begin
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      idx_d   = req_addr[ADDR_W+1:2];
      wdata_d = req_wdata;
      be_d    = req_be;
      bad_d   = req_bad;
    end
    if (enter_resp) begin
      // Read happens before this edge's write lands, but a single
      // transaction is either a load or a store, never both.
      rdata_d = (txn_we || txn_bad) ? '0 : mem_rd_data;
      err_d   = txn_bad;
    end else if ((state_q == RESP) && rsp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench. Instance dut uses two wait
//               states; instance dut0 uses zero wait states with its
//               response channel always ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // Present a request from IDLE, pass the accepting edge, then scribble the
  // request inputs so any use of live inputs after acceptance shows up.
  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0014;
    req_wdata = 32'hBAD0_BAD0; req_be = 4'hF;
  endtask

  // Full transaction with rsp_ready = 1. lat counts edges from the accepting
  // edge (inclusive) to the first sample with rsp_valid = 1.
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata,
                     output logic err, output logic seen);
    start_req(we, addr, wdata, be);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    seen  = rsp_valid;
    rdata = rsp_rdata;
    err   = rsp_err;
    if (seen) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 00000000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin errors++; $display("FAIL reset_z: got valid %b ready %b want 0 1", z_rsp_valid, z_req_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, seen;
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er, seen);
    checks++; if (!seen || lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d seen %b want 3", lat, seen); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_resp: got err %b rdata %h want 0 00000000", er, rd); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (!seen || lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d seen %b want 3", lat, seen); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_byte_enables();
    int lat; logic [31:0] rd; logic er, seen;
    txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, rd, er, seen);
    txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, lat, rd, er, seen);
    txn(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (rd !== 32'h11BB_33DD || er !== 1'b0) begin errors++; $display("FAIL be_merge: got %h err %b want 11bb33dd 0", rd, er); end
    txn(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rd, er, seen);
    checks++; if (!seen || er !== 1'b0) begin errors++; $display("FAIL be_zero_resp: got err %b seen %b want 0 1", er, seen); end
    txn(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL be_zero_data: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, seen;
    txn(1'b1, 32'h0, 32'h0123_4567, 4'hF, lat, rd, er, seen);
    txn(1'b0, 32'h2, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_misaligned: got err %b rdata %h want 1 00000000", er, rd); end
    txn(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, lat, rd, er, seen);
    checks++; if (er !== 1'b1 || !seen) begin errors++; $display("FAIL err_range_store: got err %b seen %b want 1 1", er, seen); end
    txn(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (rd !== 32'h0123_4567 || er !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h err %b want 01234567 0", rd, er); end
    txn(1'b1, 32'h3FC, 32'h7766_5544, 4'hF, lat, rd, er, seen);
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (rd !== 32'h7766_5544 || er !== 1'b0) begin errors++; $display("FAIL last_word: got %h err %b want 77665544 0", rd, er); end
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_high_addr: got err %b rdata %h want 1 00000000", er, rd); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er, seen;
    int waited;
    txn(1'b1, 32'h40, 32'h5A5A_1234, 4'hF, lat, rd, er, seen);
    rsp_ready = 1'b0;
    start_req(1'b0, 32'h40, 32'h0, 4'h0);
    waited = 1;
    while (!rsp_valid && waited < 40) begin @(posedge clk); #1; waited++; end
    checks++; if (!rsp_valid || waited !== 3) begin errors++; $display("FAIL bp_latency: got %0d valid %b want 3 1", waited, rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A_1234 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid %b rdata %h err %b ready %b want 1 5a5a1234 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready %b valid %b want 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, seen;
    int waited;
    txn(1'b1, 32'h30, 32'h0, 4'hF, lat, rd, er, seen);
    start_req(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait: got ready %b valid %b rdata %h err %b want 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er, seen);
    checks++; if (!seen || rd !== 32'h0) begin errors++; $display("FAIL rst_no_commit: got %h seen %b want 00000000 1", rd, seen); end
    // Reset while a nonzero load response is being held.
    txn(1'b1, 32'h44, 32'h1357_9BDF, 4'hF, lat, rd, er, seen);
    rsp_ready = 1'b0;
    start_req(1'b0, 32'h44, 32'h0, 4'h0);
    waited = 1;
    while (!rsp_valid && waited < 40) begin @(posedge clk); #1; waited++; end
    checks++; if (rsp_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL rst_pre_data: got %h want 13579bdf", rsp_rdata); end
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_resp: got valid %b rdata %h err %b ready %b want 0 00000000 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] zd [4];
    zd[0] = 32'h0BAD_F00D; zd[1] = 32'h1234_5678;
    zd[2] = 32'h8765_4321; zd[3] = 32'hFACE_B00C;
    for (int i = 0; i < 4; i++) begin
      z_req_valid = 1'b1; z_req_we = 1'b1;
      z_req_addr = 32'h100 + 32'(4 * i); z_req_wdata = zd[i]; z_req_be = 4'hF;
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      @(posedge clk); #1;
    end
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== zd[i] || z_rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL zw_resp %0d: got valid %b rdata %h err %b want 1 %h 0",
                 i, z_rsp_valid, z_rsp_rdata, z_rsp_err, zd[i]);
      end
      if (i == 3) z_req_valid = 1'b0;
      else        z_req_addr  = 32'h100 + 32'(4 * (i + 1));
      @(posedge clk); #1;
      checks++;
      if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL zw_gap %0d: got valid %b ready %b want 0 1", i, z_rsp_valid, z_req_ready);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dmem_responder
`default_nettype wire
